// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
//
// AHB-Lite responder backed by a word-organised memory. Every accepted
// transfer is answered with an optional run of wait states followed by an
// OKAY data phase. Illegal accesses get the two-cycle ERROR response and never
// touch the memory.
//
// Parameters
//   AHB_ADDR_WIDTH  address width (32)
//   AHB_DATA_WIDTH  data width (only 32 is supported)
//   MEM_DEPTH       number of 32-bit words, power of 2
//   BASE_ADDR       byte address of word 0, aligned to MEM_DEPTH*4
//   WAIT_STATES     HREADYOUT-low cycles before each OKAY data phase (0..7)
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   byte address
//   HTRANS     in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size (0=byte, 1=halfword, 2=word)
//   HBURST     in   burst type, ignored (every beat carries its own HADDR)
//   HWDATA     in   write data, valid during the data phase
//   HREADY     in   bus-level ready
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  read data, zero outside the DONE cycle
//   dbg_state  out  current FSM state (see ST_* encodings)
//
// Handshake: an address phase is taken on a rising edge where
// HSEL & HREADY & HTRANS[1] are all high; it plays the role of "valid" and
// HREADY the role of "ready". The data phase that follows completes on the
// first edge where HREADY is high again. While HREADY is low the address-phase
// signals are not sampled; the master must hold them.
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
    parameter int                        AHB_ADDR_WIDTH = 32,
    parameter int                        AHB_DATA_WIDTH = 32,
    parameter int                        MEM_DEPTH      = 256,
    parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int                        WAIT_STATES    = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [AHB_DATA_WIDTH-1:0] HRDATA,
    output logic [2:0]                dbg_state
);

    // Word index width and the lowest address bit above the memory window.
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int TAG_LSB = IDX_W + 2;

    // HSIZE encodings that this responder can serve.
    localparam logic [2:0] H8_SIZE  = 3'd0;
    localparam logic [2:0] H16_SIZE = 3'd1;
    localparam logic [2:0] H32_SIZE = 3'd2;

    // FSM encodings.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);

    // -----------------------------------------------------------------------
    // State and data-phase registers
    // -----------------------------------------------------------------------
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       wait_cnt;
    logic [2:0]       wait_cnt_nxt;
    logic             load_dp;

    logic [IDX_W-1:0] dp_idx;
    logic             dp_write;
    logic [3:0]       dp_be;

    logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Address-phase decode
    // -----------------------------------------------------------------------
    logic             accept;
    logic             size_err;
    logic             align_err;
    logic             range_err;
    logic             acc_err;
    logic [3:0]       acc_be;
    logic [IDX_W-1:0] acc_idx;

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign acc_idx = HADDR[TAG_LSB-1:2];

    always_comb begin
        size_err  = (HSIZE > H32_SIZE);
        align_err = 1'b0;
        if (HSIZE == H16_SIZE) begin
            align_err = HADDR[0];
        end else if (HSIZE == H32_SIZE) begin
            align_err = |HADDR[1:0];
        end
        // BASE_ADDR is window-aligned, so the window test reduces to
        // comparing the address bits above the word index.
        range_err = (HADDR[AHB_ADDR_WIDTH-1:TAG_LSB] != BASE_ADDR[AHB_ADDR_WIDTH-1:TAG_LSB]);
        acc_err   = size_err | align_err | range_err;
    end

    // Little-endian byte lanes; HWDATA lanes are used in place.
    always_comb begin
        acc_be = 4'b0000;
        case (HSIZE)
            H8_SIZE:  acc_be = 4'b0001 << HADDR[1:0];
            H16_SIZE: acc_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default:  acc_be = 4'b1111;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        load_dp      = 1'b0;
        case (state)
            // HREADYOUT is high in these states, so a new address phase can
            // be taken here; DONE and ERR2 overlap it with the ending beat.
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) begin
                    load_dp = 1'b1;
                    if (acc_err) begin
                        state_nxt = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            // One WAIT cycle per count; the last one hands over to DONE with
            // the counter landing on zero.
            ST_WAIT: begin
                if (wait_cnt <= 3'd1) begin
                    state_nxt    = ST_DONE;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            ST_ERR1: begin
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_idx   <= '0;
            dp_write <= 1'b0;
            dp_be    <= 4'b0000;
        end else if (load_dp) begin
            dp_idx   <= acc_idx;
            dp_write <= HWRITE;
            dp_be    <= acc_be;
        end
    end

    // -----------------------------------------------------------------------
    // Memory: written on the edge that ends DONE. Reset forces IDLE, so a
    // transfer interrupted by reset can never reach this write.
    // -----------------------------------------------------------------------
    logic mem_we;

    assign mem_we = (state == ST_DONE) && dp_write;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (dp_be[n]) begin
                    mem[dp_idx][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from state alone so reset takes effect immediately.
    // -----------------------------------------------------------------------
    assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (state == ST_DONE) ? mem[dp_idx] : '0;
    assign dbg_state = state;

    // Burst type and the low HTRANS bit carry no information for this
    // responder.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// Bench for ahb_slave_mem. Two instances share clock and reset: index 0 has
// no wait states, index 1 has two. Stimulus is a list of address phases that
// a pipelined driver plays onto one instance; expected responses are pushed
// to exp_q when an address phase is driven and popped when its data phase
// ends.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem;

    localparam int         EW        = 38;  // {chk_rdata, resp, n_low[3:0], rdata[31:0]}
    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_BUSY    = 2'd1;
    localparam logic [1:0] T_NONSEQ  = 2'd2;
    localparam logic [1:0] T_SEQ     = 2'd3;
    localparam int         MAX_STIM  = 64;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];
    logic [2:0]  dbg_state [2];

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HBURST(hburst[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
        .dbg_state(dbg_state[0])
    );

    ahb_slave_mem #(.WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HBURST(hburst[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard state ----------------
    int              checks;
    int              errors;
    logic [EW-1:0]   exp_q[$];
    logic [31:0]     model_mem [2][256];
    logic [15:0]     rdy_hist;
    int              hist_n;

    // ---------------- stimulus list ----------------
    logic        s_sel   [MAX_STIM];
    logic [1:0]  s_trans [MAX_STIM];
    logic        s_write [MAX_STIM];
    logic [2:0]  s_size  [MAX_STIM];
    logic [31:0] s_addr  [MAX_STIM];
    logic [31:0] s_wdata [MAX_STIM];
    int          s_n;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic exp_err(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1 && addr[0]) return 1'b1;
        if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
        if (addr >= 32'h0000_0400) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(input int d, input logic [2:0] size,
                                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        logic [3:0]  be;
        int          idx;
        idx = int'(addr[9:2]);
        w   = model_mem[d][idx];
        case (size)
            3'd0:    be = 4'(1 << int'(addr[1:0]));
            3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        for (int n = 0; n < 4; n++) begin
            if (be[n]) w[8*n +: 8] = wd[8*n +: 8];
        end
        model_mem[d][idx] = w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic add(input logic sel, input logic [1:0] trans, input logic write,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        s_sel[s_n]   = sel;
        s_trans[s_n] = trans;
        s_write[s_n] = write;
        s_size[s_n]  = size;
        s_addr[s_n]  = addr;
        s_wdata[s_n] = wdata;
        s_n++;
    endtask

    // Plays s_* onto instance d with AHB pipelining: a new address phase is
    // presented whenever HREADY is high, HWDATA follows one edge later.
    task automatic run_stim(input int d);
        int            i;
        int            cur;
        int            acc;
        int            low;
        int            cyc;
        logic          idle_dp;
        logic          nxt_idle;
        logic          err;
        logic [31:0]   rd;
        logic [EW-1:0] e;
        i = 0; cur = -1; acc = -1; low = 0; cyc = 0;
        idle_dp = 1'b0; nxt_idle = 1'b0;
        rdy_hist = '0; hist_n = 0;
        @(negedge clk);
        forever begin
            // observe the cycle that is ending
            if (cur >= 0) begin
                rdy_hist = {rdy_hist[14:0], hreadyout[d]};
                hist_n++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty d=%0d addr=%h", d, s_addr[cur]);
                    cur = -1;
                end else if (hreadyout[d] !== 1'b1) begin
                    e = exp_q[0];
                    low++;
                    checks++;
                    if (hresp[d] !== e[36] || hrdata[d] !== 32'h0) begin
                        errors++;
                        $display("FAIL stall_cycle d=%0d addr=%h hresp=%b hrdata=%h required hresp=%b hrdata=0",
                                 d, s_addr[cur], hresp[d], hrdata[d], e[36]);
                    end
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (hresp[d] !== e[36] || low != int'(e[35:32])) begin
                        errors++;
                        $display("FAIL completion d=%0d addr=%h hresp=%b low_cycles=%0d required hresp=%b low_cycles=%0d",
                                 d, s_addr[cur], hresp[d], low, e[36], e[35:32]);
                    end
                    if (e[37]) begin
                        checks++;
                        if (hrdata[d] !== e[31:0]) begin
                            errors++;
                            $display("FAIL rdata d=%0d addr=%h got=%h required=%h",
                                     d, s_addr[cur], hrdata[d], e[31:0]);
                        end
                    end
                    cur = -1;
                end
            end else if (idle_dp) begin
                checks++;
                if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_phase d=%0d hreadyout=%b hresp=%b hrdata=%h required 1 0 0",
                             d, hreadyout[d], hresp[d], hrdata[d]);
                end
            end
            idle_dp = 1'b0;
            // drive the next address phase when the bus is ready
            if (hreadyout[d] === 1'b1) begin
                if (i < s_n) begin
                    hsel[d]   = s_sel[i];
                    htrans[d] = s_trans[i];
                    hwrite[d] = s_write[i];
                    hsize[d]  = s_size[i];
                    haddr[d]  = s_addr[i];
                    hburst[d] = 3'd1;
                    if (s_sel[i] && s_trans[i][1]) begin
                        acc = i;
                        err = exp_err(s_size[i], s_addr[i]);
                        if (!err && s_write[i]) model_write(d, s_size[i], s_addr[i], s_wdata[i]);
                        rd = model_mem[d][int'(s_addr[i][9:2])];
                        exp_q.push_back({(!err && !s_write[i]), err,
                                         (err ? 4'd1 : 4'(wait_of(d))), rd});
                    end else begin
                        nxt_idle = 1'b1;
                    end
                    i++;
                end else begin
                    hsel[d]   = 1'b0;
                    htrans[d] = T_IDLE;
                end
            end
            if (i >= s_n && cur < 0 && acc < 0 && !nxt_idle) break;
            @(posedge clk);
            #1;
            if (acc >= 0) begin
                cur = acc; acc = -1; low = 0;
                hwdata[d] = s_wdata[cur];
            end
            idle_dp  = nxt_idle;
            nxt_idle = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                checks++; errors++;
                $display("FAIL timeout d=%0d pending=%0d", d, exp_q.size());
                exp_q.delete();
                break;
            end
        end
        hsel[d]   = 1'b0;
        htrans[d] = T_IDLE;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_values d=%0d hreadyout=%b hresp=%b hrdata=%h required 1 0 0",
                         d, hreadyout[d], hresp[d], hrdata[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_rw(input int d);
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h3FC, 32'hC0FF_EE01);  // last word in the window
        add(1'b1, T_SEQ,    1'b0, 3'd2, 32'h3FC, 32'h0);
        run_stim(d);
    endtask

    task automatic test_byte_write(input int d);
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0000_0000);
        add(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h13, 32'hA5A5_A5A5);
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h14, 32'h0000_0000);
        add(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h16, 32'h1234_5678);
        add(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h15, 32'h9ABC_DEF0);
        add(1'b1, T_NONSEQ, 1'b0, 3'd0, 32'h14, 32'h0);
        run_stim(d);
    endtask

    task automatic test_wait_burst();
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h1111_1111);
        add(1'b1, T_SEQ,    1'b1, 3'd2, 32'h14, 32'h2222_2222);
        run_stim(1);
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
        add(1'b1, T_SEQ,    1'b0, 3'd2, 32'h14, 32'h0);
        run_stim(1);
        checks++;
        if (hist_n != 6 || rdy_hist[5:0] !== 6'b001001) begin
            errors++;
            $display("FAIL wait_pattern cycles=%0d pattern=%b required cycles=6 pattern=001001",
                     hist_n, rdy_hist[5:0]);
        end
    endtask

    task automatic test_errors(input int d);
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h00, 32'h0BAD_F00D);
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h04, 32'h5555_AAAA);
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h02, 32'hFFFF_FFFF);    // misaligned word
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h400, 32'hFFFF_FFFF);   // first byte past the window
        add(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h05, 32'hFFFF_FFFF);    // misaligned halfword
        add(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h04, 32'h0);
        run_stim(d);
    endtask

    task automatic test_busy_idle();
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h30, 32'h3030_3030);
        add(1'b1, T_BUSY,   1'b1, 3'd2, 32'h34, 32'hFFFF_FFFF);
        add(1'b1, T_SEQ,    1'b1, 3'd2, 32'h34, 32'h3434_3434);
        add(1'b1, T_BUSY,   1'b1, 3'd2, 32'h38, 32'hEEEE_EEEE);
        add(1'b1, T_SEQ,    1'b1, 3'd2, 32'h38, 32'h3838_3838);
        add(1'b1, T_IDLE,   1'b1, 3'd2, 32'h30, 32'hDDDD_DDDD);
        add(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h38, 32'hBADB_AD00);   // not selected
        add(1'b1, T_NONSEQ, 1'b1, 3'd3, 32'h30, 32'h0);           // 64-bit size
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
        add(1'b1, T_SEQ,    1'b0, 3'd2, 32'h34, 32'h0);
        add(1'b1, T_SEQ,    1'b0, 3'd2, 32'h38, 32'h0);
        run_stim(0);
    endtask

    task automatic test_reset_mid();
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h1111_2222);
        run_stim(1);
        @(negedge clk);
        hsel[1] = 1'b1; htrans[1] = T_NONSEQ; hwrite[1] = 1'b1;
        hsize[1] = 3'd2; haddr[1] = 32'h20;
        @(posedge clk);
        #1;
        hsel[1] = 1'b0; htrans[1] = T_IDLE; hwdata[1] = 32'hBAD0_BAD0;
        @(negedge clk);
        checks++;
        if (hreadyout[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait hreadyout=%b required 0", hreadyout[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (hreadyout[1] !== 1'b1 || hresp[1] !== 1'b0 || hrdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs hreadyout=%b hresp=%b hrdata=%h required 1 0 0",
                     hreadyout[1], hresp[1], hrdata[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        s_n = 0;
        add(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);  // model still holds the old word
        run_stim(1);
    endtask

    task automatic test_random(input int d);
        logic [31:0] a;
        logic [1:0]  tr;
        s_n = 0;
        for (int w = 16; w < 32; w++) add(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom());
        run_stim(d);
        s_n = 0;
        for (int k = 0; k < 24; k++) begin
            a  = 32'h40 + 32'($urandom_range(0, 63));
            tr = ($urandom_range(0, 1) == 1) ? T_SEQ : T_NONSEQ;
            case ($urandom_range(0, 6))
                0, 1:    add(1'b1, tr, 1'b1, 3'd0, a, $urandom());
                2:       add(1'b1, tr, 1'b1, 3'd1, {a[31:1], 1'b0}, $urandom());
                3:       add(1'b1, tr, 1'b0, 3'd2, {a[31:2], 2'b00}, 32'h0);
                4:       add(1'b1, tr, 1'b0, 3'd0, a, 32'h0);
                5:       add(1'b1, tr, 1'b1, 3'd2, {a[31:2], 2'b01}, $urandom());
                default: add(1'b1, T_IDLE, 1'b0, 3'd2, a, 32'h0);
            endcase
        end
        run_stim(d);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        s_n    = 0;
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = T_IDLE; hwrite[d] = 1'b0;
            hsize[d] = '0; hburst[d] = '0; hwdata[d] = '0;
        end
        test_reset();
        test_word_rw(0);
        test_word_rw(1);
        test_byte_write(0);
        test_wait_burst();
        test_errors(0);
        test_errors(1);
        test_busy_idle();
        test_reset_mid();
        test_random(0);
        test_random(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder (slave) that ends each AHB transfer and backs it with a small word-organised memory. It sits on the bus as the counterpart to the AHB master/driver models in the AHB environment. It accepts the shared AHB types: HTRANS_E, HSIZE_E, HBURST_E, and 32-bit address and data. It answers with HREADYOUT, HRESP and HRDATA, using a programmable number of wait states and a two-cycle ERROR response for illegal accesses.

## Interface
- AHB_ADDR_WIDTH, 32, address width; matches the package constant.
- AHB_DATA_WIDTH, 32, data width. Only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be aligned to MEM_DEPTH*4.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY data phase. Legal range 0..7.

Ports:
- HCLK  in  1  bus clock. All logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  AHB_ADDR_WIDTH  byte address.
- HTRANS  in  2  HTRANS_E encoding: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  HSIZE_E encoding.
- HBURST  in  3  HBURST_E encoding. Accepted and ignored; each beat carries its own HADDR.
- HWDATA  in  AHB_DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; the previous data phase completes when this is high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  AHB_DATA_WIDTH  read data.

## Operation
- Address-phase accept: on an edge where HSEL & HREADY & HTRANS[1] are all high. The block registers addr, write, size and error flag into the data-phase registers.
- HTRANS IDLE or BUSY, or HSEL low: no access. The next data phase is zero-wait OKAY.
- Error conditions, checked at accept:
  - HSIZE > H32_SIZE.
  - Misalignment: H16 with HADDR[0]=1, or H32 with HADDR[1:0]≠0.
  - Address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4).
- State machine:
  - IDLE: no transfer pending. HREADYOUT=1, HRESP=0.
  - WAIT: counter counts down from WAIT_STATES. HREADYOUT=0, HRESP=0. Moves to DONE when the counter reaches 0.
  - DONE: HREADYOUT=1, HRESP=0. The access commits this cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on accept:
  - Legal access: WAIT if WAIT_STATES>0, else DONE.
  - Illegal access: ERR1, then ERR2.
- Leaving DONE or ERR2: a new accept in that same cycle starts the next transfer (pipelined back-to-back). Otherwise the block returns to IDLE.
- Writes:
  - Memory updates at the DONE edge.
  - Byte enables are little-endian, taken from size and addr[1:0]. HWDATA lanes are used in place: byte n occupies bits [8n+7:8n].
  - Erroring transfers never write.
- Reads:
  - HRDATA = mem[word index] during DONE. The full word is driven, whatever the size.
  - HRDATA = 0 in every other state.
  - A read that directly follows a write to the same word returns the new data, because the write commits on the edge before the read's DONE cycle.
- Memory contents are not reset. After reset, contents are undefined until written.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0.
- Reset asserted mid-transfer: the pending transfer is discarded, no memory write occurs, and outputs take their reset values immediately.
- Latency with WAIT_STATES=0: address phase at cycle N, data phase at cycle N+1 with HREADYOUT=1.
- Latency with WAIT_STATES=W: HREADYOUT is low for cycles N+1..N+W and high at N+1+W.
- ERROR response: ERR1 at N+1, ERR2 at N+2. HRESP stays high across both cycles. HREADYOUT is low then high.
- Address phase during a stall: HADDR and the other control signals are not sampled while HREADY=0. The master holds them per protocol.
- Throughput: one transfer per 1+W cycles, back-to-back with no bubble.

## Test plan
- WAIT_STATES=0, H32 write 32'hDEADBEEF to 0x10, then read 0x10 → write completes in 1 cycle with OKAY; the read data phase returns HRDATA=32'hDEADBEEF.
- Byte write 8'hA5 to 0x13 over an existing 32'h0, then a word read → HRDATA=32'hA500_0000.
- WAIT_STATES=2, NONSEQ read then SEQ read → HREADYOUT pattern 0,0,1,0,0,1; both beats return OKAY.
- H32 access at 0x02, then an access at BASE_ADDR+MEM_DEPTH*4 → for each: HRESP=1 for 2 cycles, HREADYOUT 0 then 1; memory unchanged on a readback.
- BUSY and IDLE transfers interleaved in an INCR burst → zero-wait OKAY and no memory change. HSIZE=H64 → ERROR.
- Assert HRESET during WAIT of a write to 0x20 → HREADYOUT=1 and HRESP=0 the same cycle; a readback shows the old value at 0x20.
